writeback_scoreboard: RTL and testbench

//   Write end of the 32x32 register file in the 5-stage MIPS pipeline: MEM/WB pipeline

---
 rtl/writeback_scoreboard.sv | 134 +++++++++++++
 tb/tb_writeback_scoreboard.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_scoreboard.sv
// -----------------------------------------------------------------------------
// writeback_scoreboard
//   Write end of the 32x32 register file in a 5-stage MIPS pipeline.
//   - MEM/WB pipeline register plus writeback mux, driving the file's
//     WE3/A3/WD3 write port one clock after the MEM stage.
//   - Per-register pending-write counters. Decode stalls on a RAW hazard
//     against any register that still has a write in flight.
//   - Same-cycle WB->ID bypass. The file only writes on the clock edge, but
//     decode reads it combinationally during the writeback cycle.
//
// Ports
//   clock, Regreset         rising-edge clock, asynchronous active-high reset
//   RegWriteM, MemtoRegM,   MEM-stage write enable, load/ALU select,
//   WriteRegM, ALUOutM,     destination register, ALU result
//   ReadDataM               and load data
//   IssueD, RegWriteD,      decode issue valid, decode writes a register,
//   WriteRegD, RsD, RtD     decode destination register, source registers
//   RD1, RD2                register file read data
//   WE3, A3, WD3            register file write port (registered)
//   SrcAD, SrcBD            bypassed decode operands
//   StallD                  RAW-hazard stall for fetch/decode
//   ScbErr                  sticky counter overflow/underflow flag
// -----------------------------------------------------------------------------
module writeback_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clock,
  input  logic              Regreset,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [ADDR_W-1:0] WriteRegM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic              IssueD,
  input  logic              RegWriteD,
  input  logic [ADDR_W-1:0] WriteRegD,
  input  logic [ADDR_W-1:0] RsD,
  input  logic [ADDR_W-1:0] RtD,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] SrcAD,
  output logic [DATA_W-1:0] SrcBD,
  output logic              StallD,
  output logic              ScbErr
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // MEM/WB pipeline register
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] a3_q,  a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;

  // Scoreboard state
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic              err_q, err_d;
  logic [NREG-1:0]   busy;
  logic              inc_en;

  assign we3_d = RegWriteM;
  assign a3_d  = WriteRegM;
  assign wd3_d = MemtoRegM ? ReadDataM : ALUOutM;

  // Register 0 never holds a pending write, so it is excluded from inc and
  // from busy; its counter slot is tied to zero.
  assign inc_en = IssueD && RegWriteD && !StallD && (WriteRegD != '0);

  // A write retiring this cycle no longer counts as pending, so decode may
  // proceed and pick the value up from the bypass instead of the file.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (cnt_q[r] - CNT_W'(we3_q && (a3_q == ADDR_W'(r)))) != '0;
    end
  end

  assign StallD = busy[RsD] | busy[RtD];

  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < NREG; r++) begin
      logic inc, dec;
      inc = inc_en && (WriteRegD == ADDR_W'(r));
      dec = we3_q && (a3_q == ADDR_W'(r));
      if (inc && !dec) begin
        if (cnt_q[r] == CNT_MAX) err_d = 1'b1;         // saturate on overflow
        else                     cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0)      err_d = 1'b1;         // hold at zero on underflow
        else                     cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
    cnt_d[0] = '0;
  end

  // NOTE: the counter array is reset like ordinary flops (not left as uninitialised RAM) because a reset must drop every pending write at once.
  always_ff @(posedge clock or posedge Regreset) begin
    if (Regreset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
      err_q <= 1'b0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      err_q <= err_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign WE3    = we3_q;
  assign A3     = a3_q;
  assign WD3    = wd3_q;
  assign ScbErr = err_q;

  // Bypass beats file data; register 0 always reads the file (which returns zero).
  assign SrcAD = ((RsD != '0) && we3_q && (a3_q == RsD)) ? wd3_q : RD1;
  assign SrcBD = ((RtD != '0) && we3_q && (a3_q == RtD)) ? wd3_q : RD2;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_writeback_scoreboard
//   Directed bench for writeback_scoreboard. Inputs change 1 ns after each
//   rising edge; outputs are sampled 1 ns later, well away from the edge.
//   Internal counter values are inferred from StallD behaviour.
// -----------------------------------------------------------------------------
module tb_writeback_scoreboard;

  logic        clock = 1'b0;
  logic        Regreset;
  logic        RegWriteM, MemtoRegM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, ReadDataM;
  logic        IssueD, RegWriteD;
  logic [4:0]  WriteRegD, RsD, RtD;
  logic [31:0] RD1, RD2;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3, SrcAD, SrcBD;
  logic        StallD, ScbErr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  writeback_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clock(clock), .Regreset(Regreset),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
    .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .IssueD(IssueD), .RegWriteD(RegWriteD), .WriteRegD(WriteRegD),
    .RsD(RsD), .RtD(RtD), .RD1(RD1), .RD2(RD2),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .SrcAD(SrcAD), .SrcBD(SrcBD), .StallD(StallD), .ScbErr(ScbErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All control inputs back to a quiet cycle; data/read ports keep recognisable values.
  task automatic idle();
    RegWriteM = 1'b0; MemtoRegM = 1'b0; WriteRegM = '0;
    IssueD    = 1'b0; RegWriteD = 1'b0; WriteRegD = '0;
    RsD       = '0;   RtD       = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    IssueD = 1'b1; RegWriteD = 1'b1; WriteRegD = rd;
  endtask

  task automatic mem_write(input logic [4:0] rd, input logic [31:0] alu);
    RegWriteM = 1'b1; MemtoRegM = 1'b0; WriteRegM = rd; ALUOutM = alu;
  endtask

  initial begin
    Regreset  = 1'b1;
    idle();
    ALUOutM   = 32'h0;
    ReadDataM = 32'h0;
    RD1       = 32'h1111_1111;
    RD2       = 32'h2222_2222;

    // ---------------- reset state ----------------
    RsD = 5'd7; RtD = 5'd9;
    #2;
    check("rst_we3",    WE3,    0);
    check("rst_a3",     A3,     0);
    check("rst_wd3",    WD3,    0);
    check("rst_err",    ScbErr, 0);
    check("rst_stall",  StallD, 0);
    check("rst_srca",   SrcAD,  32'h1111_1111);
    check("rst_srcb",   SrcBD,  32'h2222_2222);
    tick();
    Regreset = 1'b0;
    idle();

    // ---------------- WB mux (load path then ALU path) ----------------
    issue(5'd5);
    settle();
    check("mux_issue_nostall", StallD, 0);
    tick();                                   // cnt[5]=1
    idle();
    RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd5;
    ReadDataM = 32'hDEAD_BEEF; ALUOutM = 32'h1;
    RsD = 5'd5;
    settle();
    check("mux_pending_stall", StallD, 1);
    tick();
    idle();
    RsD = 5'd5;
    MemtoRegM = 1'b0; ALUOutM = 32'h1234_5678;
    settle();
    check("mux_we3",        WE3,   1);
    check("mux_a3",         A3,    5);
    check("mux_wd3_load",   WD3,   32'hDEAD_BEEF);
    check("mux_retire_nostall", StallD, 0);
    check("mux_bypass_a",   SrcAD, 32'hDEAD_BEEF);
    check("mux_nobypass_b", SrcBD, 32'h2222_2222);
    tick();                                   // cnt[5]=0
    settle();
    check("mux_we3_off",    WE3,   0);
    check("mux_wd3_alu",    WD3,   32'h1234_5678);
    check("mux_idle_nostall", StallD, 0);
    check("mux_no_bypass_we0", SrcAD, 32'h1111_1111);

    // ---------------- RAW stall on r8 ----------------
    idle();
    issue(5'd8);
    tick();                                   // cnt[8]=1
    idle();
    issue(5'd2); RsD = 5'd8;                  // dependent instruction, writes r2
    mem_write(5'd8, 32'h0000_0088);
    settle();
    check("raw_stall", StallD, 1);
    tick();                                   // stalled: r2 not counted
    RegWriteM = 1'b0;
    settle();
    check("raw_wb_nostall", StallD, 0);
    check("raw_wb_bypass",  SrcAD, WD3);
    check("raw_wb_value",   SrcAD, 32'h0000_0088);
    tick();                                   // issue r2 accepted, cnt[8]=0
    idle();
    RtD = 5'd2;
    mem_write(5'd2, 32'h0000_0022);
    settle();
    check("raw_r2_stall", StallD, 1);
    tick();
    idle();
    RtD = 5'd2;
    settle();
    check("raw_r2_single_count", StallD, 0);  // would stay high if the stalled issue counted
    check("raw_bypass_b", SrcBD, 32'h0000_0022);
    tick();

    // ---------------- back-to-back writes to r3 ----------------
    idle();
    issue(5'd3);
    tick();
    tick();                                   // cnt[3]=2
    idle();
    RtD = 5'd3;
    mem_write(5'd3, 32'h3);
    settle();
    check("b2b_stall_cnt2", StallD, 1);
    tick();                                   // first retires next edge
    settle();
    check("b2b_stall_retire1", StallD, 1);    // 2 pending, 1 retiring
    tick();                                   // cnt[3]=1, second in WB
    RegWriteM = 1'b0;
    settle();
    check("b2b_we3_second", WE3, 1);
    check("b2b_last_retire_nostall", StallD, 0);
    tick();                                   // cnt[3]=0
    settle();
    check("b2b_done_nostall", StallD, 0);

    // ---------------- simultaneous inc/dec on r4 ----------------
    idle();
    issue(5'd4);
    tick();                                   // cnt[4]=1
    idle();
    mem_write(5'd4, 32'h4);
    tick();                                   // r4 now in WB
    idle();
    issue(5'd4);                              // inc and dec together
    tick();                                   // cnt[4] stays 1
    idle();
    RsD = 5'd4;
    settle();
    check("simul_cnt_kept", StallD, 1);
    check("simul_no_err",   ScbErr, 0);
    mem_write(5'd4, 32'h44);
    tick();
    RegWriteM = 1'b0;
    settle();
    check("simul_retire_nostall", StallD, 0);
    tick();                                   // cnt[4]=0
    settle();
    check("simul_idle_nostall", StallD, 0);
    check("simul_err_clear",    ScbErr, 0);

    // ---------------- register 0 ----------------
    idle();
    issue(5'd0);
    settle();
    check("r0_issue_nostall", StallD, 0);
    tick();
    idle();
    settle();
    check("r0_never_busy", StallD, 0);
    mem_write(5'd0, 32'h0000_00F0);
    tick();
    idle();
    settle();
    check("r0_wb_we3",     WE3,   1);
    check("r0_no_bypass_a", SrcAD, 32'h1111_1111);
    check("r0_no_bypass_b", SrcBD, 32'h2222_2222);
    tick();
    settle();
    check("r0_no_underflow", ScbErr, 0);

    // ---------------- overflow on r9 ----------------
    idle();
    issue(5'd9);
    tick();
    tick();
    tick();                                   // cnt[9]=3
    settle();
    check("ovf_three_ok", ScbErr, 0);
    tick();                                   // fourth issue saturates
    idle();
    settle();
    check("ovf_err_set", ScbErr, 1);
    RsD = 5'd9;
    mem_write(5'd9, 32'h9);
    tick();                                   // WB #1
    settle();
    check("ovf_cnt3_retire1", StallD, 1);
    tick();                                   // cnt 2, WB #2
    settle();
    check("ovf_cnt2_retire1", StallD, 1);
    tick();                                   // cnt 1, WB #3
    RegWriteM = 1'b0;
    settle();
    check("ovf_cnt1_retire1", StallD, 0);
    tick();                                   // cnt 0
    settle();
    check("ovf_drained_nostall", StallD, 0);
    check("ovf_err_sticky",      ScbErr, 1);

    // ---------------- asynchronous reset mid-stream ----------------
    idle();
    issue(5'd11);
    tick();                                   // cnt[11]=1
    idle();
    issue(5'd12);
    mem_write(5'd11, 32'hBBBB_0011);
    tick();                                   // cnt[12]=1, r11 in WB
    idle();
    RsD = 5'd12; RtD = 5'd12;
    settle();
    check("mid_stall_before_rst", StallD, 1);
    #2;                                       // mid-cycle, no clock edge
    Regreset = 1'b1;
    settle();
    check("mid_rst_we3",   WE3,    0);
    check("mid_rst_a3",    A3,     0);
    check("mid_rst_wd3",   WD3,    0);
    check("mid_rst_stall", StallD, 0);
    check("mid_rst_err",   ScbErr, 0);
    check("mid_rst_srca",  SrcAD,  32'h1111_1111);
    tick();
    Regreset = 1'b0;
    tick();
    settle();
    check("post_rst_no_write", WE3,    0);
    check("post_rst_dropped",  StallD, 0);

    // ---------------- underflow on r10 ----------------
    idle();
    mem_write(5'd10, 32'hA);
    tick();                                   // r10 in WB with cnt[10]=0
    idle();
    settle();
    check("unf_before_edge", ScbErr, 0);
    tick();
    settle();
    check("unf_err_set", ScbErr, 1);
    tick();
    tick();
    settle();
    check("unf_err_sticky", ScbErr, 1);
    #2;
    Regreset = 1'b1;
    settle();
    check("unf_err_cleared", ScbErr, 0);
    tick();
    Regreset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
